// File: rtl/dht11_sampler.sv
// Periodic start sequencer for a DHT11 controller: issues start pulses, waits for
// done with a timeout, latches valid readings as 2-digit BCD and counts failures.
module dht11_sampler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       dht11_done,
  input  logic       dht11_valid,
  input  logic [7:0] rhdata,
  input  logic [7:0] t_data,
  output logic       start,
  output logic [7:0] rh_bcd,
  output logic [7:0] t_bcd,
  output logic       data_ok,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int IW       = $clog2(PERIOD_MS + 1);
  localparam int TW       = $clog2(TIMEOUT_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [IW-1:0] PERIOD_LD  = IW'(PERIOD_MS);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_MS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_BUSY  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] int_cnt_q, int_cnt_d, int_dec;
  logic [TW-1:0] to_cnt_q, to_cnt_d, to_dec;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          data_ok_q, data_ok_d;
  logic [7:0]    rh_bcd_q, rh_bcd_d;
  logic [7:0]    t_bcd_q, t_bcd_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          tick;

  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    if (v > 8'd99) begin
      return 8'h99;
    end
    return ((v / 8'd10) << 4) | (v % 8'd10);
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    int_dec = (tick && int_cnt_q != '0) ? int_cnt_q - IW'(1) : int_cnt_q;
    to_dec  = (tick && to_cnt_q != '0) ? to_cnt_q - TW'(1) : to_cnt_q;

    state_d   = state_q;
    int_cnt_d = int_cnt_q;
    to_cnt_d  = to_cnt_q;
    rh_bcd_d  = rh_bcd_q;
    t_bcd_d   = t_bcd_q;
    data_ok_d = data_ok_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        int_cnt_d = PERIOD_LD;
        if (enable) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        int_cnt_d = int_dec;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (int_dec == '0) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // The START cycle is the first cycle of the new interval, so a tick here counts.
        int_cnt_d = PERIOD_LD - IW'(tick);
        to_cnt_d  = TIMEOUT_LD - TW'(tick);
        state_d   = S_BUSY;
      end
      default: begin
        int_cnt_d = int_dec;
        to_cnt_d  = to_dec;
        if (dht11_done) begin
          state_d = enable ? S_WAIT : S_IDLE;
          if (dht11_valid) begin
            rh_bcd_d  = to_bcd(rhdata);
            t_bcd_d   = to_bcd(t_data);
            data_ok_d = 1'b1;
          end else begin
            data_ok_d = 1'b0;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end else if (to_dec == '0) begin
          state_d   = enable ? S_WAIT : S_IDLE;
          data_ok_d = 1'b0;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end
      end
    endcase

    if ((state_d == S_WAIT && state_q != S_WAIT) || state_d == S_START) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      int_cnt_q <= '0;
      to_cnt_q  <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_ok_q <= 1'b0;
      rh_bcd_q  <= 8'h00;
      t_bcd_q   <= 8'h00;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      int_cnt_q <= int_cnt_d;
      to_cnt_q  <= to_cnt_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      data_ok_q <= data_ok_d;
      rh_bcd_q  <= rh_bcd_d;
      t_bcd_q   <= t_bcd_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign start   = start_q;
  assign busy    = busy_q;
  assign data_ok = data_ok_q;
  assign rh_bcd  = rh_bcd_q;
  assign t_bcd   = t_bcd_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dht11_sampler.sv
// Bench for dht11_sampler: 1 tick per clock; expected start times, BCD values and
// error counts come from a cycle-arithmetic model of the sequencing rules.
module tb_dht11_sampler;

  localparam int CLK_HZ  = 1000;
  localparam int PERIOD  = 20;
  localparam int TIMEOUT = 5;

  logic       clk = 1'b0;
  logic       rst, enable, dht11_done, dht11_valid;
  logic [7:0] rhdata, t_data;
  logic       start, data_ok, busy;
  logic [7:0] rh_bcd, t_bcd, err_cnt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_start;
  logic [7:0] exp_rh, exp_t;
  logic       exp_ok;
  int         exp_err;

  dht11_sampler #(.CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD), .TIMEOUT_MS(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dht11_done(dht11_done),
    .dht11_valid(dht11_valid), .rhdata(rhdata), .t_data(t_data),
    .start(start), .rh_bcd(rh_bcd), .t_bcd(t_bcd), .data_ok(data_ok),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd_of(input int v);
    if (v > 99) return 8'h99;
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk8({tag, "_rh_bcd"}, rh_bcd, exp_rh);
    chk8({tag, "_t_bcd"}, t_bcd, exp_t);
    chk1({tag, "_data_ok"}, data_ok, exp_ok);
    chk8({tag, "_err_cnt"}, err_cnt, 8'(exp_err));
  endtask

  task automatic wait_start(output int s);
    int n;
    n = 0;
    while (start !== 1'b1 && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    s = cyc;
    checks++;
    assert (start === 1'b1 && cyc == exp_start) else begin
      errors++;
      $error("FAIL start_time: observed cycle %0d (start=%b) expected cycle %0d", cyc, start, exp_start);
    end
  endtask

  // k = cycle after START at which done is pulsed (0 = never); drop_en = cycle to drop enable
  task automatic run_txn(input int k, input logic vld, input logic [7:0] rh,
                         input logic [7:0] t, input int drop_en);
    int  s, jend;
    bit  acc;
    wait_start(s);
    jend = (k + 1 > TIMEOUT) ? k + 1 : TIMEOUT;
    acc  = (k >= 1) && (k <= TIMEOUT - 1);
    for (int j = 1; j <= jend; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk1("start_width", start, 1'b0);
        chk1("busy_after_start", busy, 1'b1);
      end
      if (j == TIMEOUT - 1 && (k == 0 || k >= TIMEOUT - 1))
        chk1("busy_before_expiry", busy, 1'b1);
      if (j == drop_en) enable = 1'b0;
      dht11_done = (j == k);
      if (j == k) begin
        dht11_valid = vld;
        rhdata      = rh;
        t_data      = t;
      end else begin
        dht11_valid = 1'($urandom);
        rhdata      = 8'($urandom);
        t_data      = 8'($urandom);
      end
    end
    if (acc && vld) begin
      exp_rh = bcd_of(int'(rh));
      exp_t  = bcd_of(int'(t));
      exp_ok = 1'b1;
    end else begin
      exp_ok  = 1'b0;
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    end
    $display("txn start@%0d done_k=%0d valid=%0b rh=%0d t=%0d -> rh_bcd=%h t_bcd=%h ok=%0b err=%0d",
             s, k, vld, rh, t, rh_bcd, t_bcd, data_ok, err_cnt);
    chk_outputs("txn");
    chk1("busy_after_txn", busy, 1'b0);
    if (enable) exp_start = s + PERIOD;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, nstart;
    rst = 1'b0; enable = 1'b0; dht11_done = 1'b0; dht11_valid = 1'b0;
    rhdata = 8'h00; t_data = 8'h00;
    exp_rh = 8'h00; exp_t = 8'h00; exp_ok = 1'b0; exp_err = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk1("rst_start", start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk_outputs("rst");

    // First start 20 ticks after enable is sampled
    rst = 1'b1; enable = 1'b1;
    exp_start = cyc + 1 + PERIOD;

    run_txn(3, 1'b1, 8'd55, 8'd23, 0);          // valid reading
    run_txn(2, 1'b0, 8'd70, 8'd12, 0);          // bad checksum
    run_txn(0, 1'b0, 8'd0, 8'd0, 0);            // timeout
    run_txn(TIMEOUT - 1, 1'b1, 8'd9, 8'd99, 0); // done on expiry cycle wins
    run_txn(TIMEOUT + 2, 1'b1, 8'd44, 8'd45, 0);// late done ignored -> timeout
    run_txn(1, 1'b1, 8'd150, 8'd200, 0);        // saturating BCD

    for (int i = 0; i < 20; i++)
      run_txn($urandom_range(0, 7), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 120)), 0);

    // Enable drop while waiting: back to IDLE, full period after re-enable
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    enable = 1'b1;
    exp_start = cyc + 1 + PERIOD;
    run_txn(2, 1'b1, 8'd31, 8'd7, 0);

    // Drive err_cnt into saturation
    for (int i = 0; i < 300; i++)
      run_txn(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, TIMEOUT - 1),
              1'b0, 8'($urandom), 8'($urandom), 0);
    chk8("err_saturated", err_cnt, 8'hFF);

    // Enable drops mid-BUSY: done still processed, then no further starts
    run_txn(3, 1'b1, 8'd67, 8'd18, 1);
    nstart = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (start === 1'b1) nstart++;
    end
    chk8("no_start_when_disabled", 8'(nstart), 8'd0);
    enable = 1'b1;
    exp_start = cyc + 1 + PERIOD;

    // Reset in the middle of BUSY
    wait_start(s);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_rh = 8'h00; exp_t = 8'h00; exp_ok = 1'b0; exp_err = 0;
    chk1("midrst_start", start, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk_outputs("midrst");
    rst = 1'b1;
    dht11_done = 1'b1; dht11_valid = 1'b1; rhdata = 8'd42; t_data = 8'd24;
    exp_start = cyc + 1 + PERIOD;
    @(negedge clk);
    dht11_done = 1'b0;
    chk_outputs("stale_done");
    run_txn(4, 1'b1, 8'd88, 8'd5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
